// File: rtl/clock_digit_draw_scheduler.sv
// Redraws changed HH:MM digits as seven-segment glyphs through the LT24 pixel-write port.
// Only dirty digits are redrawn, lowest index first, one pixel per accepted transfer.
module clock_digit_draw_scheduler #(
  parameter int          X_ORIGIN  = 20,
  parameter int          Y_ORIGIN  = 128,
  parameter int          DIGIT_W   = 40,
  parameter int          DIGIT_H   = 64,
  parameter int          SEG_T     = 8,
  parameter int          DIGIT_GAP = 12,
  parameter logic [15:0] FG_COLOUR = 16'hFFFF,
  parameter logic [15:0] BG_COLOUR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        resetApp,
  input  logic [3:0]  valueHr1,
  input  logic [3:0]  valueHr0,
  input  logic [3:0]  valueMin1,
  input  logic [3:0]  valueMin0,
  input  logic        pixelReady,
  output logic [7:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic [15:0] pixelData,
  output logic        pixelWrite,
  output logic        busy,
  output logic        frameDone
);

  localparam int LXW   = $clog2(DIGIT_W);
  localparam int LYW   = $clog2(DIGIT_H);
  localparam int H2    = DIGIT_H / 2;
  localparam int PITCH = DIGIT_W + DIGIT_GAP;
  localparam logic [LXW-1:0] LX_ONE  = LXW'(1);
  localparam logic [LXW-1:0] LX_LAST = LXW'(DIGIT_W - 1);
  localparam logic [LYW-1:0] LY_ONE  = LYW'(1);
  localparam logic [LYW-1:0] LY_LAST = LYW'(DIGIT_H - 1);

  localparam logic [1:0] S_WAIT_INIT = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_LOAD      = 2'd2;
  localparam logic [1:0] S_DRAW      = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [3:0]     value [4];
  logic [3:0]     shadow_q [4];
  logic [3:0]     shadow_d [4];
  logic [3:0]     dirty_q, dirty_d;
  logic [3:0]     drawVal_q, drawVal_d;
  logic [1:0]     digit_q, digit_d;
  logic [LXW-1:0] lx_q, lx_d;
  logic [LYW-1:0] ly_q, ly_d;
  logic [7:0]     xAddr_q, xAddr_d;
  logic [8:0]     yAddr_q, yAddr_d;
  logic [15:0]    pixelData_q, pixelData_d;
  logic           pixelWrite_q, pixelWrite_d;
  logic           frameDone_q, frameDone_d;

  logic [1:0]     loadDigit;
  logic           capture;
  logic [3:0]     pixVal;
  logic [1:0]     pixDigit;
  logic [LXW-1:0] pixX;
  logic [LYW-1:0] pixY;

  assign value[0] = valueHr1;
  assign value[1] = valueHr0;
  assign value[2] = valueMin1;
  assign value[3] = valueMin0;

  // Segment order {a,b,c,d,e,f,g}; codes above 9 stay blank.
  function automatic logic [15:0] glyphPixel(input logic [3:0] val, input int x, input int y);
    logic [6:0] seg;
    logic       lit;
    case (val)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000000;
    endcase
    lit = (seg[6] && y < SEG_T)
       || (seg[5] && x >= DIGIT_W - SEG_T && y < H2)
       || (seg[4] && x >= DIGIT_W - SEG_T && y >= H2)
       || (seg[3] && y >= DIGIT_H - SEG_T)
       || (seg[2] && x < SEG_T && y >= H2)
       || (seg[1] && x < SEG_T && y < H2)
       || (seg[0] && y >= H2 - SEG_T / 2 && y < H2 + SEG_T / 2);
    return lit ? FG_COLOUR : BG_COLOUR;
  endfunction

  always_comb begin
    loadDigit = 2'd0;
    casez (dirty_q)
      4'b???1: loadDigit = 2'd0;
      4'b??10: loadDigit = 2'd1;
      4'b?100: loadDigit = 2'd2;
      4'b1000: loadDigit = 2'd3;
      default: loadDigit = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    dirty_d      = dirty_q;
    drawVal_d    = drawVal_q;
    digit_d      = digit_q;
    lx_d         = lx_q;
    ly_d         = ly_q;
    pixelWrite_d = pixelWrite_q;
    frameDone_d  = 1'b0;
    capture      = 1'b0;
    pixVal       = drawVal_q;
    pixDigit     = digit_q;
    pixX         = lx_q;
    pixY         = ly_q;

    if (state_q == S_WAIT_INIT) begin
      if (!resetApp) begin
        shadow_d = value;
        dirty_d  = 4'b1111;
        state_d  = S_IDLE;
      end
    end else if (resetApp) begin
      pixelWrite_d = 1'b0;
      state_d      = S_WAIT_INIT;
    end else begin
      // Clear before set so a change arriving during LOAD keeps the digit dirty.
      if (state_q == S_LOAD) dirty_d[loadDigit] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (value[i] != shadow_q[i]) begin
          shadow_d[i] = value[i];
          dirty_d[i]  = 1'b1;
        end
      end
      case (state_q)
        S_IDLE: if (dirty_q != 4'd0) state_d = S_LOAD;
        S_LOAD: begin
          digit_d      = loadDigit;
          drawVal_d    = shadow_q[loadDigit];
          lx_d         = '0;
          ly_d         = '0;
          pixVal       = shadow_q[loadDigit];
          pixDigit     = loadDigit;
          pixX         = '0;
          pixY         = '0;
          capture      = 1'b1;
          pixelWrite_d = 1'b1;
          state_d      = S_DRAW;
        end
        S_DRAW: if (pixelWrite_q && pixelReady) begin
          if (lx_q == LX_LAST && ly_q == LY_LAST) begin
            pixelWrite_d = 1'b0;
            frameDone_d  = (dirty_d == 4'd0);
            state_d      = S_IDLE;
          end else begin
            if (lx_q == LX_LAST) begin
              lx_d = '0;
              ly_d = ly_q + LY_ONE;
            end else begin
              lx_d = lx_q + LX_ONE;
            end
            pixX    = lx_d;
            pixY    = ly_d;
            capture = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Address and colour are registered together so they change only on a transfer.
  always_comb begin
    xAddr_d     = xAddr_q;
    yAddr_d     = yAddr_q;
    pixelData_d = pixelData_q;
    if (capture) begin
      xAddr_d     = 8'(X_ORIGIN + int'(pixDigit) * PITCH + int'(pixX));
      yAddr_d     = 9'(Y_ORIGIN + int'(pixY));
      pixelData_d = glyphPixel(pixVal, int'(pixX), int'(pixY));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_WAIT_INIT;
      for (int i = 0; i < 4; i++) shadow_q[i] <= 4'd0;
      dirty_q      <= 4'b1111;
      drawVal_q    <= 4'd0;
      digit_q      <= 2'd0;
      lx_q         <= '0;
      ly_q         <= '0;
      xAddr_q      <= 8'd0;
      yAddr_q      <= 9'd0;
      pixelData_q  <= 16'd0;
      pixelWrite_q <= 1'b0;
      frameDone_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      for (int i = 0; i < 4; i++) shadow_q[i] <= shadow_d[i];
      dirty_q      <= dirty_d;
      drawVal_q    <= drawVal_d;
      digit_q      <= digit_d;
      lx_q         <= lx_d;
      ly_q         <= ly_d;
      xAddr_q      <= xAddr_d;
      yAddr_q      <= yAddr_d;
      pixelData_q  <= pixelData_d;
      pixelWrite_q <= pixelWrite_d;
      frameDone_q  <= frameDone_d;
    end
  end

  assign xAddr      = xAddr_q;
  assign yAddr      = yAddr_q;
  assign pixelData  = pixelData_q;
  assign pixelWrite = pixelWrite_q;
  assign frameDone  = frameDone_q;
  assign busy       = (state_q == S_LOAD) || (state_q == S_DRAW);

endmodule

// File: doc/clock_digit_draw_scheduler.md
Name: clock_digit_draw_scheduler

Overview:
Sequences pixel writes from the four clock time digits (HH:MM) into the LT24 display driver's pixel-write interface. It tracks which digits changed and redraws only those. Each digit is rendered as a seven-segment glyph inside a fixed cell. It sits between the time-keeping counters and the LT24 display driver, and holds off until the driver releases resetApp.

Parameters:
X_ORIGIN, 20, x of digit 0 (Hr1) cell left edge
Y_ORIGIN, 128, y of all cells' top edge
DIGIT_W, 40, cell width in pixels
DIGIT_H, 64, cell height in pixels (even)
SEG_T, 8, segment thickness in pixels (even, 2*SEG_T < DIGIT_W)
DIGIT_GAP, 12, horizontal gap between cells
FG_COLOUR, 16'hFFFF, RGB565 colour for lit segment
BG_COLOUR, 16'h0000, RGB565 colour for unlit/background

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
resetApp  input  1  high while the LT24 driver initialises; no writes are allowed while high
valueHr1  input  4  tens of hours (digit 0)
valueHr0  input  4  units of hours (digit 1)
valueMin1  input  4  tens of minutes (digit 2)
valueMin0  input  4  units of minutes (digit 3)
pixelReady  input  1  driver can accept a pixel this cycle
xAddr  output  8  pixel x address
yAddr  output  9  pixel y address
pixelData  output  16  RGB565 pixel value
pixelWrite  output  1  pixel write request
busy  output  1  high in LOAD/DRAW
frameDone  output  1  one-cycle pulse when the dirty set becomes empty after a draw

Behaviour:
- Reset (reset=0, async): state=WAIT_INIT; xAddr=0, yAddr=0, pixelData=0, pixelWrite=0, busy=0, frameDone=0; shadow values=0; dirty=4'b1111.
- WAIT_INIT: stays while resetApp=1. On resetApp=0, sets dirty=4'b1111, captures all four inputs into the shadows, then goes to IDLE.
- Change detection, every cycle outside WAIT_INIT: if value_i != shadow_i, then shadow_i<=value_i and dirty_i<=1.
- IDLE: if dirty!=0, goes to LOAD; else holds.
- LOAD (1 cycle):
  - Selects the lowest-index dirty digit d.
  - Snapshots shadow_d into drawVal and clears dirty_d.
  - Sets local lx=0, ly=0, then goes to DRAW.
  - If a set and a clear of dirty_d happen in the same cycle, the set wins.
- DRAW:
  - Outputs xAddr = X_ORIGIN + d*(DIGIT_W+DIGIT_GAP) + lx, yAddr = Y_ORIGIN + ly, pixelWrite=1.
  - pixelData is registered together with the address.
  - A transfer occurs on a clock edge where pixelWrite=1 and pixelReady=1. Address and data are held stable until the transfer.
  - After a transfer, lx increments. When lx wraps from DIGIT_W-1 to 0, ly increments (row-major, x fastest).
  - After the transfer of (DIGIT_W-1, DIGIT_H-1), pixelWrite drops. If dirty is empty, frameDone pulses for 1 cycle; either way the state returns to IDLE.
- Segments (local coordinates; half H2=DIGIT_H/2):
  - a: ly<SEG_T
  - g: H2-SEG_T/2 <= ly < H2+SEG_T/2
  - d: ly >= DIGIT_H-SEG_T
  - f: lx<SEG_T and ly<H2
  - b: lx >= DIGIT_W-SEG_T and ly<H2
  - e: lx<SEG_T and ly>=H2
  - c: lx >= DIGIT_W-SEG_T and ly>=H2
  - Pixel = FG_COLOUR if any lit segment covers it, else BG_COLOUR.
  - Segment sets: 0:abcdef, 1:bc, 2:abdeg, 3:abcdg, 4:bcfg, 5:acdfg, 6:acdefg, 7:abc, 8:all, 9:abcdfg.
  - Values 10–15 light no segments (blank cell).
- A digit changing during its own DRAW does not alter that draw, because it uses the drawVal snapshot. It is marked dirty again and redrawn afterwards.
- resetApp rising in any state except WAIT_INIT: pixelWrite=0 next cycle, the draw is aborted, and the state goes to WAIT_INIT.
- Address arithmetic is unsigned. The parameters are required to keep cells inside 240x320; no clipping is done.
- busy=1 exactly in LOAD and DRAW.

Test Plan:
- Init, pixelReady always 1, inputs 0,9,0,5 → no pixelWrite while resetApp=1. After release: 4×2560 transfers, digit order 0..3. First transfer x=20,y=128; last x=215,y=191. One frameDone pulse.
- Blank digit: after the full draw, valueMin0 4'd5→4'd15 → only digit 3 is redrawn, x range 176..215. All 2560 pixels are 16'h0000.
- Glyph check, digit 1 = 1: pixel (lx=0,ly=0) is BG and (lx=39,ly=10) is FG. Digit 1 = 8, pixel (lx=20,ly=32) → FG (segment g).
- Backpressure: pixelReady toggles 1-of-3 during a draw → xAddr/yAddr/pixelData stay stable while pixelWrite=1 and pixelReady=0. Exactly 2560 transfers; no pixel is skipped or duplicated.
- Change mid-draw: valueHr0 changes 3→4 while digit 1 is at ly=10 → the current draw completes with glyph 3, then digit 1 is redrawn with 4. frameDone occurs only after the second draw.
- Reset mid-draw: resetApp pulses high for 5 cycles at ly=30 → pixelWrite=0 the next cycle. After release, all 4 digits are redrawn. A separate async reset=0 mid-cycle forces all outputs to 0 immediately.
